// File: rtl/hamming_pkg.sv
// Shared definitions for the extended Hamming(16,11) SECDED code.
// Holds the codeword/data widths, where data and parity bits sit in a codeword,
// the error classification type, and the codeword -> data extraction function.
// Bit 0 is overall even parity; bits 1,2,4,8 are Hamming parity; the 11 data
// bits fill the remaining positions in ascending order.
package hamming_pkg;

    localparam int unsigned CW_W   = 16;
    localparam int unsigned DATA_W = 11;
    localparam int unsigned SYN_W  = 4;

    localparam logic [SYN_W-1:0] DATA_POS [DATA_W] = '{
        4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    localparam logic [SYN_W-1:0] PARITY_POS [SYN_W] = '{4'd1, 4'd2, 4'd4, 4'd8};
    localparam logic [SYN_W-1:0] OVERALL_POS = 4'd0;

    typedef enum logic [1:0] {
        ErrNone,
        ErrCorrected,
        ErrUncorrectable
    } err_kind_e;

    function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = cw[DATA_POS[i]];
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity generator for a 16-bit codeword.
// Ports:
//   word     - codeword to check
//   syndrome - XOR of the indices (1..15) of all set bits; names the flipped bit
//   parity   - XOR of all 16 bits; 1 means an odd number of bit errors
module hamming_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  word,
    output logic [SYN_W-1:0] syndrome,
    output logic             parity
);

    always_comb begin
        syndrome = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (word[i]) begin
                syndrome = syndrome ^ SYN_W'(i);
            end
        end
    end

    assign parity = ^word;

endmodule

// File: rtl/hamming_secded_decoder.sv
// Two-stage pipelined SECDED decoder for the extended Hamming(16,11) code.
// Stage 1 captures the channel word with its syndrome and parity; stage 2
// classifies, corrects single-bit errors and registers the result.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready/channel_word - input stream (one codeword per beat)
//   out_valid/out_ready           - output stream handshake
//   data_out                      - decoded 11-bit data
//   err_corrected/err_uncorrectable/err_pos - error flags and syndrome of the beat
//   cnt_clear                     - clears both counters (wins over an increment)
//   corr_count/uncor_count        - saturating counts of accepted flagged beats
module hamming_secded_decoder
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   channel_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err_corrected,
    output logic              err_uncorrectable,
    output logic [SYN_W-1:0]  err_pos,
    input  logic              cnt_clear,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncor_count
);

    logic              en;
    logic [SYN_W-1:0]  in_syn;
    logic              in_par;

    logic              s1_valid_q;
    logic [CW_W-1:0]   s1_word_q;
    logic [SYN_W-1:0]  s1_syn_q;
    logic              s1_par_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] data_q;
    logic              corr_q;
    logic              uncor_q;
    logic [SYN_W-1:0]  pos_q;
    logic [CNT_W-1:0]  corr_cnt_q;
    logic [CNT_W-1:0]  uncor_cnt_q;

    err_kind_e         kind;
    logic [CW_W-1:0]   fixed_word;
    logic [DATA_W-1:0] fixed_data;

    hamming_syndrome u_syndrome (
        .word     (channel_word),
        .syndrome (in_syn),
        .parity   (in_par)
    );

    // The whole pipeline moves together; it only freezes when a result is waiting.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Odd parity means a single error at position s1_syn_q. When the syndrome is
    // zero that flips bit 0, which carries no data, so no special case is needed.
    always_comb begin
        kind       = ErrNone;
        fixed_word = s1_word_q;
        if (s1_par_q) begin
            kind                 = ErrCorrected;
            fixed_word[s1_syn_q] = ~s1_word_q[s1_syn_q];
        end else if (s1_syn_q != '0) begin
            kind = ErrUncorrectable;
        end
        fixed_data = extract_data(fixed_word);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_word_q   <= '0;
            s1_syn_q    <= '0;
            s1_par_q    <= 1'b0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            corr_q      <= 1'b0;
            uncor_q     <= 1'b0;
            pos_q       <= '0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_word_q <= channel_word;
                s1_syn_q  <= in_syn;
                s1_par_q  <= in_par;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                data_q  <= fixed_data;
                corr_q  <= (kind == ErrCorrected);
                uncor_q <= (kind == ErrUncorrectable);
                pos_q   <= s1_syn_q;
            end else begin
                corr_q  <= 1'b0;
                uncor_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            corr_cnt_q  <= '0;
            uncor_cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            if (corr_q && (corr_cnt_q != '1)) begin
                corr_cnt_q <= corr_cnt_q + CNT_W'(1);
            end
            if (uncor_q && (uncor_cnt_q != '1)) begin
                uncor_cnt_q <= uncor_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid         = out_valid_q;
    assign data_out          = data_q;
    assign err_corrected     = corr_q;
    assign err_uncorrectable = uncor_q;
    assign err_pos           = pos_q;
    assign corr_count        = corr_cnt_q;
    assign uncor_count       = uncor_cnt_q;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Self-checking bench for hamming_secded_decoder: a reference encoder and a
// nearest-codeword search predict each result, which is queued on acceptance
// and compared when the decoder hands the beat downstream.
module tb_hamming_secded_decoder;

    localparam int unsigned CNT_W = 4;
    localparam int SAT = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [15:0]       channel_word = 16'h0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [10:0]       data_out;
    logic              err_corrected;
    logic              err_uncorrectable;
    logic [3:0]        err_pos;
    logic              cnt_clear = 1'b0;
    logic [CNT_W-1:0]  corr_count;
    logic [CNT_W-1:0]  uncor_count;

    always #5 clk = ~clk;

    hamming_secded_decoder #(
        .CNT_W (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .channel_word      (channel_word),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .data_out          (data_out),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .err_pos           (err_pos),
        .cnt_clear         (cnt_clear),
        .corr_count        (corr_count),
        .uncor_count       (uncor_count)
    );

    typedef struct {
        logic [10:0] data;
        logic        corr;
        logic        uncor;
        logic [3:0]  pos;
        int          t_in;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int corr_model = 0;
    int uncor_model = 0;

    function automatic bit is_pow2(input int i);
        return (i == 1) || (i == 2) || (i == 4) || (i == 8);
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] c);
        logic [10:0] d;
        int k;
        d = '0;
        k = 0;
        for (int i = 1; i < 16; i++) begin
            if (!is_pow2(i)) begin
                d[k] = c[i];
                k++;
            end
        end
        return d;
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] c;
        logic x;
        int k;
        c = '0;
        k = 0;
        for (int i = 1; i < 16; i++) begin
            if (!is_pow2(i)) begin
                c[i] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            x = 1'b0;
            for (int i = 1; i < 16; i++) begin
                if (((i >> b) & 1) == 1 && !is_pow2(i)) x = x ^ c[i];
            end
            c[1 << b] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    // Nearest valid codeword within one flip, otherwise a detected double error.
    function automatic exp_t model(input logic [15:0] cw);
        exp_t e;
        logic [15:0] f;
        logic [3:0] s;
        e.data = extract(cw);
        e.corr = 1'b0;
        e.uncor = 1'b0;
        e.pos = 4'd0;
        e.t_in = 0;
        if (encode(extract(cw)) != cw) begin
            for (int b = 0; b < 16; b++) begin
                f = cw ^ (16'h1 << b);
                if (!e.corr && encode(extract(f)) == f) begin
                    e.corr = 1'b1;
                    e.pos = 4'(b);
                    e.data = extract(f);
                end
            end
            if (!e.corr) begin
                s = 4'd0;
                for (int i = 1; i < 16; i++) if (cw[i]) s = s ^ 4'(i);
                e.uncor = 1'b1;
                e.pos = s;
            end
        end
        return e;
    endfunction

    function automatic logic [15:0] corrupt(input logic [10:0] d, input int nflip);
        logic [15:0] c;
        int a;
        int b;
        c = encode(d);
        a = $urandom_range(0, 15);
        b = (a + $urandom_range(1, 15)) % 16;
        if (nflip >= 1) c[a] = ~c[a];
        if (nflip >= 2) c[b] = ~c[b];
        return c;
    endfunction

    // One clock of stimulus: drives inputs, then pops the scoreboard for a
    // consumed result and pushes a prediction for an accepted word.
    task automatic drive(input logic v, input logic [15:0] w, input logic ordy, input logic clr,
                         output logic acc, output int got, output exp_t e);
        exp_t n;
        @(negedge clk);
        in_valid = v;
        channel_word = w;
        out_ready = ordy;
        cnt_clear = clr;
        #1;
        cyc++;
        got = 0;
        e.data = '0;
        e.corr = 1'b0;
        e.uncor = 1'b0;
        e.pos = '0;
        e.t_in = 0;
        if (out_valid && ordy) begin
            if (sb.size() == 0) begin
                got = 2;
            end else begin
                got = 1;
                e = sb.pop_front();
            end
        end
        if (clr) begin
            corr_model = 0;
            uncor_model = 0;
        end else if (got == 1) begin
            if (e.corr && corr_model < SAT) corr_model++;
            if (e.uncor && uncor_model < SAT) uncor_model++;
        end
        acc = v && in_ready;
        if (acc) begin
            n = model(w);
            n.t_in = cyc;
            sb.push_back(n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        channel_word = 16'h000E;
        out_ready = 1'b1;
        cnt_clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        corr_model = 0;
        uncor_model = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        total++;
        if (data_out !== 11'h0 || err_pos !== 4'h0) begin
            bad++;
            $display("FAIL reset_data: got data=%h pos=%h required 0/0", data_out, err_pos);
        end
        total++;
        if (err_corrected !== 1'b0 || err_uncorrectable !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b%b required 00", err_corrected, err_uncorrectable);
        end
        total++;
        if (corr_count !== '0 || uncor_count !== '0) begin
            bad++;
            $display("FAIL reset_counts: got %0d/%0d required 0/0", corr_count, uncor_count);
        end
    endtask

    // Spec vectors back-to-back: clean, bit-0 error, data-bit error, double error.
    task automatic test_patterns();
        logic [15:0] words [5];
        logic acc;
        int got;
        int idx;
        exp_t e;
        words = '{16'h0000, 16'h000F, 16'h000E, 16'h0007, 16'h0003};
        idx = 0;
        for (int k = 0; k < 20 && (idx < 5 || sb.size() > 0); k++) begin
            drive(idx < 5, (idx < 5) ? words[idx] : 16'h0, 1'b1, 1'b0, acc, got, e);
            if (acc) idx++;
            if (got != 0) begin
                total++;
                if (got == 2 || {data_out, err_corrected, err_uncorrectable, err_pos}
                        !== {e.data, e.corr, e.uncor, e.pos}) begin
                    bad++;
                    $display("FAIL pattern_out: got d=%h c=%b u=%b p=%0d required d=%h c=%b u=%b p=%0d",
                             data_out, err_corrected, err_uncorrectable, err_pos,
                             e.data, e.corr, e.uncor, e.pos);
                end
                total++;
                if (got == 1 && cyc - e.t_in != 2) begin
                    bad++;
                    $display("FAIL pattern_latency: got %0d required 2", cyc - e.t_in);
                end
            end
        end
        total++;
        if (idx != 5 || sb.size() != 0) begin
            bad++;
            $display("FAIL pattern_drain: sent %0d left %0d required 5/0", idx, sb.size());
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0, acc, got, e);
        total++;
        if (corr_count !== 4'd2 || uncor_count !== 4'd1) begin
            bad++;
            $display("FAIL pattern_counts: got %0d/%0d required 2/1", corr_count, uncor_count);
        end
    endtask

    // Random data with 0..2 flips under random valid/ready gaps.
    task automatic test_random();
        logic acc;
        int got;
        int sent;
        exp_t e;
        logic [15:0] w;
        sent = 0;
        w = corrupt(11'($urandom), $urandom_range(0, 2));
        for (int k = 0; k < 400 && (sent < 40 || sb.size() > 0); k++) begin
            drive(sent < 40 && $urandom_range(0, 3) != 0, w,
                  (sent >= 40) || $urandom_range(0, 3) != 0, 1'b0, acc, got, e);
            if (acc) begin
                sent++;
                w = corrupt(11'($urandom), $urandom_range(0, 2));
            end
            if (got != 0) begin
                total++;
                if (got == 2 || {data_out, err_corrected, err_uncorrectable, err_pos}
                        !== {e.data, e.corr, e.uncor, e.pos}) begin
                    bad++;
                    $display("FAIL random_out: got d=%h c=%b u=%b p=%0d required d=%h c=%b u=%b p=%0d",
                             data_out, err_corrected, err_uncorrectable, err_pos,
                             e.data, e.corr, e.uncor, e.pos);
                end
            end
        end
        total++;
        if (sent != 40 || sb.size() != 0) begin
            bad++;
            $display("FAIL random_drain: sent %0d left %0d required 40/0", sent, sb.size());
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0, acc, got, e);
        total++;
        if (corr_count !== CNT_W'(corr_model) || uncor_count !== CNT_W'(uncor_model)) begin
            bad++;
            $display("FAIL random_counts: got %0d/%0d required %0d/%0d",
                     corr_count, uncor_count, corr_model, uncor_model);
        end
    endtask

    // Four words with the output held off for five cycles once the pipe fills.
    task automatic test_backpressure();
        logic [15:0] words [4];
        logic acc;
        int got;
        int idx;
        exp_t e;
        words[0] = corrupt(11'h2A5, 1);
        words[1] = corrupt(11'h15A, 0);
        words[2] = corrupt(11'h7FF, 2);
        words[3] = corrupt(11'h001, 1);
        idx = 0;
        for (int c = 0; c < 30 && (idx < 4 || sb.size() > 0); c++) begin
            drive(idx < 4, (idx < 4) ? words[idx] : 16'h0, c >= 7, 1'b0, acc, got, e);
            if (acc) idx++;
            if (c >= 2 && c < 7) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_handshake: got in_ready=%b out_valid=%b required 0/1",
                             in_ready, out_valid);
                end
                total++;
                if (sb.size() == 0 || {data_out, err_corrected, err_uncorrectable, err_pos}
                        !== {sb[0].data, sb[0].corr, sb[0].uncor, sb[0].pos}) begin
                    bad++;
                    $display("FAIL stall_hold: got d=%h c=%b u=%b p=%0d, head of queue differs",
                             data_out, err_corrected, err_uncorrectable, err_pos);
                end
            end
            if (got != 0) begin
                total++;
                if (got == 2 || {data_out, err_corrected, err_uncorrectable, err_pos}
                        !== {e.data, e.corr, e.uncor, e.pos}) begin
                    bad++;
                    $display("FAIL bp_out: got d=%h c=%b u=%b p=%0d required d=%h c=%b u=%b p=%0d",
                             data_out, err_corrected, err_uncorrectable, err_pos,
                             e.data, e.corr, e.uncor, e.pos);
                end
            end
        end
        total++;
        if (idx != 4 || sb.size() != 0) begin
            bad++;
            $display("FAIL bp_drain: sent %0d left %0d required 4/0", idx, sb.size());
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0, acc, got, e);
        total++;
        if (corr_count !== CNT_W'(corr_model) || uncor_count !== CNT_W'(uncor_model)) begin
            bad++;
            $display("FAIL bp_counts: got %0d/%0d required %0d/%0d",
                     corr_count, uncor_count, corr_model, uncor_model);
        end
    endtask

    // Saturation after 20 corrected beats, then a clear racing an increment.
    task automatic test_counters();
        logic acc;
        int got;
        int sent;
        exp_t e;
        sent = 0;
        for (int k = 0; k < 60 && (sent < 20 || sb.size() > 0); k++) begin
            drive(sent < 20, corrupt(11'($urandom), 1), 1'b1, 1'b0, acc, got, e);
            if (acc) sent++;
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0, acc, got, e);
        total++;
        if (corr_count !== 4'd15 || sent != 20) begin
            bad++;
            $display("FAIL count_saturate: got %0d (sent %0d) required 15", corr_count, sent);
        end
        drive(1'b1, corrupt(11'h123, 1), 1'b1, 1'b0, acc, got, e);
        drive(1'b0, 16'h0, 1'b1, 1'b0, acc, got, e);
        drive(1'b0, 16'h0, 1'b1, 1'b1, acc, got, e);
        total++;
        if (got != 1 || err_corrected !== 1'b1 || data_out !== 11'h123) begin
            bad++;
            $display("FAIL clear_beat: got out=%0d c=%b d=%h required 1/1/123",
                     got, err_corrected, data_out);
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0, acc, got, e);
        total++;
        if (corr_count !== '0 || uncor_count !== '0) begin
            bad++;
            $display("FAIL clear_priority: got %0d/%0d required 0/0", corr_count, uncor_count);
        end
    endtask

    // Reset with words in both stages: nothing may emerge afterwards.
    task automatic test_reset_mid();
        logic acc;
        int got;
        exp_t e;
        drive(1'b1, corrupt(11'h0F0, 1), 1'b1, 1'b0, acc, got, e);
        drive(1'b1, corrupt(11'h0F1, 2), 1'b1, 1'b0, acc, got, e);
        drive(1'b1, corrupt(11'h0F2, 1), 1'b1, 1'b0, acc, got, e);
        do_reset();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 11'h0 || err_pos !== 4'h0
                || err_corrected !== 1'b0 || err_uncorrectable !== 1'b0) begin
            bad++;
            $display("FAIL midreset_out: got v=%b r=%b d=%h p=%h c=%b u=%b required 0/1/0/0/0/0",
                     out_valid, in_ready, data_out, err_pos, err_corrected, err_uncorrectable);
        end
        total++;
        if (corr_count !== '0 || uncor_count !== '0) begin
            bad++;
            $display("FAIL midreset_counts: got %0d/%0d required 0/0", corr_count, uncor_count);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0, acc, got, e);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL midreset_dropped: got out_valid=%b required 0", out_valid);
            end
        end
        drive(1'b1, 16'h000F, 1'b1, 1'b0, acc, got, e);
        for (int k = 0; k < 6 && sb.size() > 0; k++) begin
            drive(1'b0, 16'h0, 1'b1, 1'b0, acc, got, e);
            if (got != 0) begin
                total++;
                if (got == 2 || data_out !== 11'h001 || err_corrected !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset_after: got d=%h c=%b required 001/0",
                             data_out, err_corrected);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL midreset_drain: left %0d required 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_patterns();
        test_random();
        test_backpressure();
        test_counters();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
